// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, instruction size,
// FSM state encoding and the {pc, instruction} entry buffered between memory and execute.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;

    typedef enum logic [0:0] {
        IFU_STATE_RUN   = 1'b0,
        IFU_STATE_ERROR = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instructions are word sized, so any fetch target must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Registered-output synchronous FIFO of fetched {pc, instr} entries.
// The head is read straight from storage registers, so nothing in the write
// path reaches the outputs combinationally. Flush wins over a same-cycle push.
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word requests over req/gnt/rvalid, buffers
// returned words with their PC, and hands {instruction, pc, pc_next} to execute.
// Redirects flush the buffer and discard responses still in flight.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_next,
    output logic        misaligned_error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    ifu_state_t    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic          credit_ok;
    logic          grant;
    logic          resp_seen;
    logic          redirect_aligned;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  fifo_din;
    fetch_entry_t  fifo_head;

    // A request is only raised when every in-flight word already owns a buffer slot.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH);
    assign imem_req  = !rst && (state == IFU_STATE_RUN) && credit_ok;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // Responses with nothing outstanding (e.g. straight after reset) are ignored.
    assign resp_seen        = imem_rvalid && (outstanding != '0);
    assign redirect_aligned = is_aligned(redirect_target);

    assign fifo_din.pc    = resp_pc;
    assign fifo_din.instr = imem_rdata;
    assign fifo_push      = resp_seen && !redirect_valid && (discard == '0)
                            && (!fifo_full || fifo_pop);
    assign fifo_pop       = out_valid && out_ready;

    assign out_valid       = (state == IFU_STATE_RUN) && !fifo_empty;
    assign out_instruction = out_valid ? fifo_head.instr : 32'd0;
    assign out_pc          = out_valid ? fifo_head.pc : 32'd0;
    assign out_pc_next     = out_valid ? (fifo_head.pc + INSTR_BYTES) : 32'd0;

    // Requests in flight after this cycle's grant and response are both counted.
    always_comb begin
        outstanding_next = outstanding;
        if (grant && !resp_seen) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!grant && resp_seen) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // Fetch control FSM: PC tracking, stale-response discard and the sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IFU_STATE_RUN;
            fetch_pc         <= RESET_PC;
            resp_pc          <= RESET_PC;
            outstanding      <= '0;
            discard          <= '0;
            misaligned_error <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= outstanding_next;
                if (redirect_aligned) begin
                    state            <= IFU_STATE_RUN;
                    misaligned_error <= 1'b0;
                end else begin
                    state            <= IFU_STATE_ERROR;
                    misaligned_error <= 1'b1;
                end
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (resp_seen) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + INSTR_BYTES;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (fifo_din),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a memory model answers grants,
// directed sequences push expected PCs, and a monitor checks every handshake.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic        misaligned_error;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    bit          mem_hold = 1'b0;

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .out_pc_next      (out_pc_next),
        .misaligned_error (misaligned_error)
    );

    always #5 clk = ~clk;

    // Contents of instruction memory at a given word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic gnt,
                                 input logic redir, input logic [31:0] target);
        out_ready       = ready;
        imem_gnt        = gnt;
        redirect_valid  = redir;
        redirect_target = target;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b1;
        mem_hold = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        checkOutput({tag, "_imem_addr"}, imem_addr, 32'h0000_0000);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_instruction"}, out_instruction, 32'd0);
        checkOutput({tag, "_out_pc"}, out_pc, 32'd0);
        checkOutput({tag, "_out_pc_next"}, out_pc_next, 32'd0);
        checkOutput({tag, "_misaligned_error"}, 32'(misaligned_error), 32'd0);
    endtask

    // Waits for all expected outputs, then stops consuming before the next edge.
    task automatic waitDrain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s: timeout with %0d outputs missing, expected 0 missing",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory model: one response per cycle, in order, one cycle after its grant.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!mem_hold && pend_q.size() > 0) begin
                a           = pend_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(a);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'd0;
            end
            #1;
            if (rst) begin
                pend_q.delete();
                imem_rvalid = 1'b0;
            end else if (imem_req && imem_gnt) begin
                pend_q.push_back(imem_addr);
            end
        end
    end

    // Monitor: every output handshake is matched against the scoreboard queue.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got pc %h expected none", out_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    checkOutput("out_pc", out_pc, exp_pc);
                    checkOutput("out_instruction", out_instruction, memWord(exp_pc));
                    checkOutput("out_pc_next", out_pc_next, exp_pc + 32'd4);
                end
            end
        end
    end

    initial begin
        int grants;

        // Power-on reset values.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        checkResetState("por");

        // Zero-wait memory, execute always ready: first output in cycle 3.
        resetDut();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("c1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("c1_imem_req", 32'(imem_req), 32'd1);
        checkOutput("c1_imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("c2_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("c3_out_valid", 32'(out_valid), 32'd1);
        waitDrain("stream_drain", 100);

        // Backpressure: exactly two grants fill the buffer, then requests stop.
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (imem_req && imem_gnt) grants++;
            @(negedge clk);
        end
        #1;
        checkOutput("bp_grant_count", 32'(grants), 32'd2);
        checkOutput("bp_imem_req", 32'(imem_req), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_hold_pc", out_pc, 32'h0);
        checkOutput("bp_hold_instr", out_instruction, memWord(32'h0));
        @(negedge clk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        out_ready = 1'b1;
        waitDrain("bp_drain", 100);

        // Reset in the middle of traffic restores every reset value.
        resetDut();
        #1;
        checkResetState("mid");

        // Grant withheld for three cycles: request and address stay put.
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_imem_req", 32'(imem_req), 32'd1);
            checkOutput("stall_imem_addr", imem_addr, 32'h0);
            @(negedge clk);
        end
        exp_q.push_back(32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("stall_addr_after_gnt", imem_addr, 32'h4);
        waitDrain("stall_drain", 100);

        // Redirect to 0x100 with two responses still in flight.
        resetDut();
        mem_hold = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        #1;
        checkOutput("redir_credit_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        #1;
        checkOutput("redir_imem_addr", imem_addr, 32'h100);
        checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
        mem_hold = 1'b0;
        waitDrain("redir_drain", 100);

        // Redirect coinciding with a response and an output handshake.
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        checkOutput("coinc_out_valid", 32'(out_valid), 32'd0);
        checkOutput("coinc_imem_addr", imem_addr, 32'h100);
        waitDrain("coinc_drain", 100);

        // Misaligned redirect parks the unit until an aligned redirect.
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("err_flag", 32'(misaligned_error), 32'd1);
            checkOutput("err_imem_req", 32'(imem_req), 32'd0);
            checkOutput("err_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 0, 32'd0);
        #1;
        checkOutput("recover_flag", 32'(misaligned_error), 32'd0);
        checkOutput("recover_imem_addr", imem_addr, 32'h200);
        checkOutput("recover_imem_req", 32'(imem_req), 32'd1);
        waitDrain("recover_drain", 100);

        // Fetch PC wraps from the top of the address space to zero.
        resetDut();
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        checkOutput("wrap_imem_addr", imem_addr, 32'hFFFF_FFF8);
        waitDrain("wrap_drain", 100);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
